// File: rtl/tlul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlul_pkg
// Brief    : TL-UL opcodes and arbiter state encoding shared by the A-arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package tlul_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_e;

endpackage : tlul_pkg
`default_nettype wire

// File: rtl/tlul_a_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : tlul_a_arbiter_if
// Brief    : Bundled master-side and slave-side TL-UL signals of the A-arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface tlul_a_arbiter_if #(
    parameter int NUM_MASTERS  = 3,
    parameter int OPCODE_WIDTH = 3,
    parameter int PARAM_WIDTH  = 3,
    parameter int SIZE_WIDTH   = 3,
    parameter int SRC_WIDTH    = 2,
    parameter int SINK_WIDTH   = 1,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MASK_WIDTH   = DATA_WIDTH / 8
);
    logic [NUM_MASTERS-1:0]              master_a_valid;
    logic [NUM_MASTERS-1:0]              master_a_ready;
    logic [NUM_MASTERS*OPCODE_WIDTH-1:0] master_a_opcode;
    logic [NUM_MASTERS*PARAM_WIDTH-1:0]  master_a_param;
    logic [NUM_MASTERS*SIZE_WIDTH-1:0]   master_a_size;
    logic [NUM_MASTERS*SRC_WIDTH-1:0]    master_a_source;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0]   master_a_address;
    logic [NUM_MASTERS*MASK_WIDTH-1:0]   master_a_mask;
    logic [NUM_MASTERS*DATA_WIDTH-1:0]   master_a_data;

    logic [NUM_MASTERS-1:0]              master_d_valid;
    logic [NUM_MASTERS-1:0]              master_d_ready;
    logic [NUM_MASTERS*OPCODE_WIDTH-1:0] master_d_opcode;
    logic [NUM_MASTERS*PARAM_WIDTH-1:0]  master_d_param;
    logic [NUM_MASTERS*SIZE_WIDTH-1:0]   master_d_size;
    logic [NUM_MASTERS*SRC_WIDTH-1:0]    master_d_source;
    logic [NUM_MASTERS*SINK_WIDTH-1:0]   master_d_sink;
    logic [NUM_MASTERS*DATA_WIDTH-1:0]   master_d_data;
    logic [NUM_MASTERS-1:0]              master_d_error;

    logic                                slave_a_valid;
    logic                                slave_a_ready;
    logic [OPCODE_WIDTH-1:0]             slave_a_opcode;
    logic [PARAM_WIDTH-1:0]              slave_a_param;
    logic [SIZE_WIDTH-1:0]               slave_a_size;
    logic [SRC_WIDTH-1:0]                slave_a_source;
    logic [ADDR_WIDTH-1:0]               slave_a_address;
    logic [MASK_WIDTH-1:0]               slave_a_mask;
    logic [DATA_WIDTH-1:0]               slave_a_data;

    logic                                slave_d_valid;
    logic                                slave_d_ready;
    logic [OPCODE_WIDTH-1:0]             slave_d_opcode;
    logic [PARAM_WIDTH-1:0]              slave_d_param;
    logic [SIZE_WIDTH-1:0]               slave_d_size;
    logic [SRC_WIDTH-1:0]                slave_d_source;
    logic [SINK_WIDTH-1:0]               slave_d_sink;
    logic [DATA_WIDTH-1:0]               slave_d_data;
    logic                                slave_d_error;

    // master: the surroundings (master sockets + downstream slave) driving the arbiter
    modport master (
        output master_a_valid, master_a_opcode, master_a_param, master_a_size,
               master_a_source, master_a_address, master_a_mask, master_a_data,
               master_d_ready, slave_a_ready,
               slave_d_valid, slave_d_opcode, slave_d_param, slave_d_size,
               slave_d_source, slave_d_sink, slave_d_data, slave_d_error,
        input  master_a_ready, master_d_valid, master_d_opcode, master_d_param,
               master_d_size, master_d_source, master_d_sink, master_d_data,
               master_d_error, slave_a_valid, slave_a_opcode, slave_a_param,
               slave_a_size, slave_a_source, slave_a_address, slave_a_mask,
               slave_a_data, slave_d_ready
    );

    // slave: the arbiter itself
    modport slave (
        input  master_a_valid, master_a_opcode, master_a_param, master_a_size,
               master_a_source, master_a_address, master_a_mask, master_a_data,
               master_d_ready, slave_a_ready,
               slave_d_valid, slave_d_opcode, slave_d_param, slave_d_size,
               slave_d_source, slave_d_sink, slave_d_data, slave_d_error,
        output master_a_ready, master_d_valid, master_d_opcode, master_d_param,
               master_d_size, master_d_source, master_d_sink, master_d_data,
               master_d_error, slave_a_valid, slave_a_opcode, slave_a_param,
               slave_a_size, slave_a_source, slave_a_address, slave_a_mask,
               slave_a_data, slave_d_ready
    );

endinterface : tlul_a_arbiter_if
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational rotating-priority picker; search starts at ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  wire logic [NUM_REQ-1:0] req_i,
    input  wire logic [IDX_W-1:0]   ptr_i,
    output logic      [NUM_REQ-1:0] gnt_o,
    output logic      [IDX_W-1:0]   gnt_idx_o
);

    logic found;
    int   cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = IDX_W'(cand);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/tlul_a_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tlul_a_arbiter
// Brief    : Shares one TL-UL slave among NUM_MASTERS sockets, remaps a_source.
//            Define TLUL_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module tlul_a_arbiter
    import tlul_pkg::*;
#(
    parameter int NUM_MASTERS  = 3,
    parameter int OPCODE_WIDTH = 3,
    parameter int PARAM_WIDTH  = 3,
    parameter int SIZE_WIDTH   = 3,
    parameter int SRC_WIDTH    = 2,
    parameter int SINK_WIDTH   = 1,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MASK_WIDTH   = DATA_WIDTH / 8
) (
    input  wire logic                   clk_100,
    input  wire logic                   reset,
    tlul_a_arbiter_if.slave             bus,
    output logic [NUM_MASTERS-1:0]      outstanding,
    output logic                        stray_d
);

    localparam int IDX_W = SRC_WIDTH;

    arb_state_e                  state_q, state_d;
    logic [NUM_MASTERS-1:0]      outstanding_q, outstanding_d;
    logic [NUM_MASTERS*SRC_WIDTH-1:0] saved_src_q;

    logic [OPCODE_WIDTH-1:0]     a_opcode_q;
    logic [PARAM_WIDTH-1:0]      a_param_q;
    logic [SIZE_WIDTH-1:0]       a_size_q;
    logic [IDX_W-1:0]            a_src_q;
    logic [ADDR_WIDTH-1:0]       a_address_q;
    logic [MASK_WIDTH-1:0]       a_mask_q;
    logic [DATA_WIDTH-1:0]       a_data_q;

    logic [NUM_MASTERS-1:0]      eligible;
    logic [NUM_MASTERS-1:0]      gnt_oh;
    logic [IDX_W-1:0]            gnt_idx;
    logic [IDX_W-1:0]            arb_ptr;
    logic                        any_elig;
    logic                        a_capture;
    logic                        a_accept;

    logic [NUM_MASTERS-1:0]      d_valid_vec;
    logic                        d_hit;
    logic                        d_sel_ready;

    // Registered outstanding keeps a just-completed master out until next cycle
    assign eligible  = bus.master_a_valid & ~outstanding_q;
    assign any_elig  = |eligible;
    assign a_capture = (state_q == IDLE) && any_elig;
    assign a_accept  = (state_q == SEND) && bus.slave_a_ready;

`ifdef TLUL_ARB_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [IDX_W-1:0] rr_ptr_q;

    always_ff @(posedge clk_100) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else if (a_accept) begin
            rr_ptr_q <= (a_src_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : a_src_q + 1'b1;
        end
    end

    assign arb_ptr = rr_ptr_q;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_MASTERS),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i     (eligible),
        .ptr_i     (arb_ptr),
        .gnt_o     (gnt_oh),
        .gnt_idx_o (gnt_idx)
    );

    always_ff @(posedge clk_100) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_elig) state_d = SEND;
            SEND:    if (bus.slave_a_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.master_a_ready = '0;
        bus.slave_a_valid  = 1'b0;
        case (state_q)
            IDLE:    bus.master_a_ready = gnt_oh;
            SEND:    bus.slave_a_valid  = 1'b1;
            default: bus.slave_a_valid  = 1'b0;
        endcase
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            a_opcode_q  <= '0;
            a_param_q   <= '0;
            a_size_q    <= '0;
            a_src_q     <= '0;
            a_address_q <= '0;
            a_mask_q    <= '0;
            a_data_q    <= '0;
            saved_src_q <= '0;
        end else if (a_capture) begin
            a_opcode_q  <= bus.master_a_opcode[gnt_idx*OPCODE_WIDTH +: OPCODE_WIDTH];
            a_param_q   <= bus.master_a_param[gnt_idx*PARAM_WIDTH +: PARAM_WIDTH];
            a_size_q    <= bus.master_a_size[gnt_idx*SIZE_WIDTH +: SIZE_WIDTH];
            a_src_q     <= gnt_idx;
            a_address_q <= bus.master_a_address[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            a_mask_q    <= bus.master_a_mask[gnt_idx*MASK_WIDTH +: MASK_WIDTH];
            a_data_q    <= bus.master_a_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            saved_src_q[gnt_idx*SRC_WIDTH +: SRC_WIDTH] <=
                bus.master_a_source[gnt_idx*SRC_WIDTH +: SRC_WIDTH];
        end
    end

    assign bus.slave_a_opcode  = a_opcode_q;
    assign bus.slave_a_param   = a_param_q;
    assign bus.slave_a_size    = a_size_q;
    assign bus.slave_a_source  = a_src_q;
    assign bus.slave_a_address = a_address_q;
    assign bus.slave_a_mask    = a_mask_q;
    assign bus.slave_a_data    = a_data_q;

    // Sources with no matching in-flight master fall through as stray
    always_comb begin
        d_valid_vec = '0;
        d_hit       = 1'b0;
        d_sel_ready = 1'b1;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (bus.slave_d_valid && (bus.slave_d_source == SRC_WIDTH'(i)) && outstanding_q[i]) begin
                d_valid_vec[i] = 1'b1;
                d_hit          = 1'b1;
                d_sel_ready    = bus.master_d_ready[i];
            end
        end
    end

    assign bus.master_d_valid = d_valid_vec;
    assign bus.slave_d_ready  = d_hit ? d_sel_ready : 1'b1;
    assign stray_d            = bus.slave_d_valid & ~d_hit;

    always_comb begin
        outstanding_d = outstanding_q & ~(d_valid_vec & bus.master_d_ready);
        if (a_accept) begin
            outstanding_d[a_src_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    assign outstanding = outstanding_q;

    generate
        for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_lane
            assign bus.master_d_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH] = bus.slave_d_opcode;
            assign bus.master_d_param[i*PARAM_WIDTH +: PARAM_WIDTH]    = bus.slave_d_param;
            assign bus.master_d_size[i*SIZE_WIDTH +: SIZE_WIDTH]       = bus.slave_d_size;
            assign bus.master_d_sink[i*SINK_WIDTH +: SINK_WIDTH]       = bus.slave_d_sink;
            assign bus.master_d_data[i*DATA_WIDTH +: DATA_WIDTH]       = bus.slave_d_data;
            assign bus.master_d_error[i]                               = bus.slave_d_error;
        end
    endgenerate

    assign bus.master_d_source = saved_src_q;

endmodule : tlul_a_arbiter
`default_nettype wire

// File: tb/tb_tlul_a_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlul_a_arbiter
// Brief    : Directed self-checking bench for the TL-UL A-channel arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlul_a_arbiter;
    import tlul_pkg::*;

    localparam int NM = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NM-1:0] outstanding;
    logic          stray_d;
    int            tests = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    tlul_a_arbiter_if #(
        .NUM_MASTERS(NM), .OPCODE_WIDTH(3), .PARAM_WIDTH(3), .SIZE_WIDTH(3),
        .SRC_WIDTH(2), .SINK_WIDTH(1), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(4)
    ) bus ();

    tlul_a_arbiter #(
        .NUM_MASTERS(NM), .OPCODE_WIDTH(3), .PARAM_WIDTH(3), .SIZE_WIDTH(3),
        .SRC_WIDTH(2), .SINK_WIDTH(1), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(4)
    ) dut (
        .clk_100     (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .outstanding (outstanding),
        .stray_d     (stray_d)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.master_a_valid   = '0;
        bus.master_a_opcode  = '0;
        bus.master_a_param   = '0;
        bus.master_a_size    = '0;
        bus.master_a_source  = '0;
        bus.master_a_address = '0;
        bus.master_a_mask    = '0;
        bus.master_a_data    = '0;
        bus.master_d_ready   = '0;
        bus.slave_a_ready    = 1'b0;
        bus.slave_d_valid    = 1'b0;
        bus.slave_d_opcode   = '0;
        bus.slave_d_param    = '0;
        bus.slave_d_size     = '0;
        bus.slave_d_source   = '0;
        bus.slave_d_sink     = '0;
        bus.slave_d_data     = '0;
        bus.slave_d_error    = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic req(input int m, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] src);
        bus.master_a_opcode[m*3 +: 3]   = op;
        bus.master_a_size[m*3 +: 3]     = 3'd2;
        bus.master_a_source[m*2 +: 2]   = src;
        bus.master_a_address[m*32 +: 32] = addr;
        bus.master_a_mask[m*4 +: 4]     = 4'hF;
        bus.master_a_data[m*32 +: 32]   = data;
        bus.master_a_valid[m]           = 1'b1;
    endtask

    task automatic accept_beat();
        bus.slave_a_ready = 1'b1;
        cycle();
        bus.slave_a_ready = 1'b0;
    endtask

    task automatic d_beat(input logic [1:0] src);
        bus.slave_d_valid  = 1'b1;
        bus.slave_d_source = src;
        bus.slave_d_opcode = ACCESS_ACK;
        bus.master_d_ready = '1;
        cycle();
        bus.slave_d_valid  = 1'b0;
        bus.master_d_ready = '0;
    endtask

    // Bring a single master through grant and slave acceptance so it is in flight
    task automatic grant_one(input int m);
        req(m, GET, 32'h3000, 32'h0, 2'd0);
        cycle();
        bus.master_a_valid[m] = 1'b0;
        accept_beat();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_dut();
        tests++; if (bus.slave_a_valid !== 1'b0) begin fails++; $display("FAIL reset_a_valid: got %b expected 0", bus.slave_a_valid); end
        tests++; if (bus.master_a_ready !== 3'b000) begin fails++; $display("FAIL reset_a_ready: got %b expected 000", bus.master_a_ready); end
        tests++; if (outstanding !== 3'b000) begin fails++; $display("FAIL reset_outstanding: got %b expected 000", outstanding); end
        tests++; if (stray_d !== 1'b0) begin fails++; $display("FAIL reset_stray: got %b expected 0", stray_d); end
        tests++; if (bus.slave_a_address !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h expected 0", bus.slave_a_address); end
    endtask

    task automatic test_single_put();
        req(0, PUT_FULL, 32'h1000, 32'hA5A5A5A5, 2'd2);
        #1;
        tests++; if (bus.master_a_ready !== 3'b001) begin fails++; $display("FAIL put_ready: got %b expected 001", bus.master_a_ready); end
        cycle();
        bus.master_a_valid[0] = 1'b0;
        #1;
        tests++; if (bus.slave_a_valid !== 1'b1) begin fails++; $display("FAIL put_a_valid: got %b expected 1", bus.slave_a_valid); end
        tests++; if (bus.slave_a_source !== 2'd0) begin fails++; $display("FAIL put_source: got %0d expected 0", bus.slave_a_source); end
        tests++; if (bus.slave_a_opcode !== PUT_FULL) begin fails++; $display("FAIL put_opcode: got %0d expected 0", bus.slave_a_opcode); end
        tests++; if (bus.slave_a_address !== 32'h1000) begin fails++; $display("FAIL put_addr: got %h expected 1000", bus.slave_a_address); end
        tests++; if (bus.slave_a_data !== 32'hA5A5A5A5) begin fails++; $display("FAIL put_data: got %h expected a5a5a5a5", bus.slave_a_data); end
        cycle();
        tests++; if (bus.slave_a_valid !== 1'b1 || bus.slave_a_address !== 32'h1000) begin fails++; $display("FAIL put_hold: got valid %b addr %h expected 1 1000", bus.slave_a_valid, bus.slave_a_address); end
        accept_beat();
        tests++; if (outstanding !== 3'b001) begin fails++; $display("FAIL put_outstanding: got %b expected 001", outstanding); end
        tests++; if (bus.slave_a_valid !== 1'b0) begin fails++; $display("FAIL put_a_drop: got %b expected 0", bus.slave_a_valid); end
        bus.slave_d_valid  = 1'b1;
        bus.slave_d_source = 2'd0;
        bus.master_d_ready = 3'b001;
        #1;
        tests++; if (bus.master_d_valid !== 3'b001) begin fails++; $display("FAIL put_d_valid: got %b expected 001", bus.master_d_valid); end
        tests++; if (bus.master_d_source[1:0] !== 2'd2) begin fails++; $display("FAIL put_d_source: got %0d expected 2", bus.master_d_source[1:0]); end
        cycle();
        bus.slave_d_valid  = 1'b0;
        bus.master_d_ready = '0;
        tests++; if (outstanding !== 3'b000) begin fails++; $display("FAIL put_d_clear: got %b expected 000", outstanding); end
    endtask

    task automatic test_fairness();
        int            order[$];
        logic [NM-1:0] g;
        reset_dut();
        for (int rnd = 0; rnd < 2; rnd++) begin
            order.delete();
            for (int m = 0; m < NM; m++) req(m, GET, 32'h2000 + 32'(m * 16), 32'h0, 2'(m));
            bus.slave_a_ready = 1'b1;
            #1;
            for (int k = 0; k < 6; k++) begin
                g = bus.master_a_ready;
                if (bus.slave_a_valid) order.push_back(int'(bus.slave_a_source));
                cycle();
                bus.master_a_valid = bus.master_a_valid & ~g;
            end
            bus.slave_a_ready = 1'b0;
            tests++; if (order.size() !== 3) begin fails++; $display("FAIL fair_count r%0d: got %0d expected 3", rnd, order.size()); end
            for (int i = 0; i < 3; i++) begin
                tests++; if (order.size() > i && order[i] !== i) begin fails++; $display("FAIL fair_order r%0d[%0d]: got %0d expected %0d", rnd, i, order[i], i); end
            end
            tests++; if (outstanding !== 3'b111) begin fails++; $display("FAIL fair_outstanding r%0d: got %b expected 111", rnd, outstanding); end
            d_beat(2'd0);
            d_beat(2'd1);
            d_beat(2'd2);
            tests++; if (outstanding !== 3'b000) begin fails++; $display("FAIL fair_drain r%0d: got %b expected 000", rnd, outstanding); end
        end
    endtask

    task automatic test_source_remap();
        req(2, GET, 32'h6000, 32'h0, 2'd1);
        #1;
        tests++; if (bus.master_a_ready !== 3'b100) begin fails++; $display("FAIL remap_ready: got %b expected 100", bus.master_a_ready); end
        cycle();
        bus.master_a_valid[2] = 1'b0;
        tests++; if (bus.slave_a_source !== 2'd2) begin fails++; $display("FAIL remap_source: got %0d expected 2", bus.slave_a_source); end
        tests++; if (bus.slave_a_opcode !== GET || bus.slave_a_address !== 32'h6000) begin fails++; $display("FAIL remap_beat: got op %0d addr %h expected 4 6000", bus.slave_a_opcode, bus.slave_a_address); end
        accept_beat();
        tests++; if (outstanding !== 3'b100) begin fails++; $display("FAIL remap_outstanding: got %b expected 100", outstanding); end
        bus.slave_d_valid  = 1'b1;
        bus.slave_d_source = 2'd2;
        bus.slave_d_opcode = ACCESS_ACK_DATA;
        bus.slave_d_data   = 32'hDEADBEEF;
        bus.master_d_ready = 3'b100;
        #1;
        tests++; if (bus.master_d_valid !== 3'b100) begin fails++; $display("FAIL remap_d_valid: got %b expected 100", bus.master_d_valid); end
        tests++; if (bus.master_d_source[5:4] !== 2'd1) begin fails++; $display("FAIL remap_d_source: got %0d expected 1", bus.master_d_source[5:4]); end
        tests++; if (bus.master_d_data[95:64] !== 32'hDEADBEEF || bus.master_d_opcode[8:6] !== ACCESS_ACK_DATA) begin fails++; $display("FAIL remap_d_fields: got data %h op %0d expected deadbeef 1", bus.master_d_data[95:64], bus.master_d_opcode[8:6]); end
        cycle();
        bus.slave_d_valid  = 1'b0;
        bus.master_d_ready = '0;
        tests++; if (outstanding !== 3'b000) begin fails++; $display("FAIL remap_clear: got %b expected 000", outstanding); end
    endtask

    task automatic test_outstanding_block();
        grant_one(1);
        req(0, GET, 32'h4000, 32'h0, 2'd3);
        req(1, GET, 32'h5000, 32'h0, 2'd3);
        #1;
        tests++; if (bus.master_a_ready !== 3'b001) begin fails++; $display("FAIL block_m0_granted: got %b expected 001", bus.master_a_ready); end
        cycle();
        bus.master_a_valid[0] = 1'b0;
        tests++; if (bus.slave_a_source !== 2'd0) begin fails++; $display("FAIL block_src: got %0d expected 0", bus.slave_a_source); end
        accept_beat();
        tests++; if (bus.master_a_ready !== 3'b000) begin fails++; $display("FAIL block_m1_held: got %b expected 000", bus.master_a_ready); end
        bus.slave_d_valid  = 1'b1;
        bus.slave_d_source = 2'd1;
        bus.master_d_ready = '1;
        #1;
        tests++; if (bus.master_a_ready !== 3'b000) begin fails++; $display("FAIL block_same_cycle: got %b expected 000", bus.master_a_ready); end
        cycle();
        bus.slave_d_valid  = 1'b0;
        bus.master_d_ready = '0;
        #1;
        tests++; if (outstanding !== 3'b001) begin fails++; $display("FAIL block_after_d: got %b expected 001", outstanding); end
        tests++; if (bus.master_a_ready !== 3'b010) begin fails++; $display("FAIL block_m1_freed: got %b expected 010", bus.master_a_ready); end
        cycle();
        bus.master_a_valid[1] = 1'b0;
        accept_beat();
        d_beat(2'd0);
        d_beat(2'd1);
        tests++; if (outstanding !== 3'b000) begin fails++; $display("FAIL block_drain: got %b expected 000", outstanding); end
    endtask

    task automatic test_d_backpressure_stray();
        grant_one(0);
        bus.slave_d_valid  = 1'b1;
        bus.slave_d_source = 2'd0;
        bus.master_d_ready = 3'b000;
        #1;
        tests++; if (bus.slave_d_ready !== 1'b0) begin fails++; $display("FAIL bp_d_ready: got %b expected 0", bus.slave_d_ready); end
        tests++; if (bus.master_d_valid !== 3'b001) begin fails++; $display("FAIL bp_d_valid: got %b expected 001", bus.master_d_valid); end
        cycle();
        tests++; if (outstanding !== 3'b001) begin fails++; $display("FAIL bp_held: got %b expected 001", outstanding); end
        bus.master_d_ready = 3'b001;
        #1;
        tests++; if (bus.slave_d_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got %b expected 1", bus.slave_d_ready); end
        cycle();
        tests++; if (outstanding !== 3'b000) begin fails++; $display("FAIL bp_clear: got %b expected 000", outstanding); end
        bus.master_d_ready = '0;
        bus.slave_d_source = 2'd3;
        #1;
        tests++; if (stray_d !== 1'b1 || bus.slave_d_ready !== 1'b1 || bus.master_d_valid !== 3'b000) begin fails++; $display("FAIL stray_src3: got stray %b ready %b dv %b expected 1 1 000", stray_d, bus.slave_d_ready, bus.master_d_valid); end
        bus.slave_d_source = 2'd1;
        #1;
        tests++; if (stray_d !== 1'b1 || bus.slave_d_ready !== 1'b1 || bus.master_d_valid !== 3'b000) begin fails++; $display("FAIL stray_idle_m1: got stray %b ready %b dv %b expected 1 1 000", stray_d, bus.slave_d_ready, bus.master_d_valid); end
        cycle();
        bus.slave_d_valid = 1'b0;
        #1;
        tests++; if (stray_d !== 1'b0) begin fails++; $display("FAIL stray_pulse_end: got %b expected 0", stray_d); end
    endtask

    task automatic test_reset_in_send();
        grant_one(1);
        req(0, PUT_FULL, 32'h7000, 32'h12345678, 2'd0);
        cycle();
        bus.master_a_valid[0] = 1'b0;
        tests++; if (bus.slave_a_valid !== 1'b1 || outstanding !== 3'b010) begin fails++; $display("FAIL rst_pre: got valid %b out %b expected 1 010", bus.slave_a_valid, outstanding); end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        tests++; if (bus.slave_a_valid !== 1'b0) begin fails++; $display("FAIL rst_send_valid: got %b expected 0", bus.slave_a_valid); end
        tests++; if (outstanding !== 3'b000) begin fails++; $display("FAIL rst_send_outstanding: got %b expected 000", outstanding); end
        tests++; if (bus.slave_a_address !== 32'h0) begin fails++; $display("FAIL rst_send_addr: got %h expected 0", bus.slave_a_address); end
        bus.slave_d_valid  = 1'b1;
        bus.slave_d_source = 2'd0;
        bus.master_d_ready = '1;
        #1;
        tests++; if (stray_d !== 1'b1 || bus.master_d_valid !== 3'b000) begin fails++; $display("FAIL rst_stray: got stray %b dv %b expected 1 000", stray_d, bus.master_d_valid); end
        cycle();
        bus.slave_d_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_single_put();
        test_fairness();
        test_source_remap();
        test_outstanding_block();
        test_d_backpressure_stray();
        test_reset_in_send();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_tlul_a_arbiter
`default_nettype wire
